// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the paged memory bus responder: widths, burst
// length, read latency and the controller state encoding.
package mcDefs;

  localparam int PAGE_W     = 4;   // page number field, address bits [15:12]
  localparam int OFFSET_W   = 12;  // word offset inside a page
  localparam int DATA_W     = 16;  // bus and array word width
  localparam int BURST_LEN  = 4;   // beats per transfer
  localparam int BEAT_W     = 2;   // beat counter width
  localparam int RD_LATENCY = 1;   // array read data arrives one cycle after mem_re

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR_DATA = 2'd3
  } state_e;

  // Offsets wrap inside the page: 12'hFFF + 1 becomes 12'h000.
  function automatic logic [OFFSET_W-1:0] next_offset(input logic [OFFSET_W-1:0] off);
    return off + 12'd1;
  endfunction

endpackage

// File: rtl/mem_bus_responder_burst_addr_gen.sv
// Burst address generator: keeps the in-page word offset and the beat
// counter, wraps the offset inside the page and flags the final beat.
module burst_addr_gen import mcDefs::*; #(
  parameter int BURST = BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [OFFSET_W-1:0] load_offset,
  input  logic                addr_step,
  input  logic                beat_step,
  output logic [OFFSET_W-1:0] offset,
  output logic                last_beat
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  logic [OFFSET_W-1:0] offset_d, offset_q;
  logic [BEAT_W-1:0]   beat_d, beat_q;

  // Next offset: load on accept, otherwise advance once per issued array access.
  always_comb begin
    offset_d = offset_q;
    if (load) begin
      offset_d = load_offset;
    end else if (addr_step) begin
      offset_d = next_offset(offset_q);
    end else begin
      offset_d = offset_q;
    end
  end

  // Next beat count: cleared on accept, advanced once per data beat on the bus.
  always_comb begin
    beat_d = beat_q;
    if (load) begin
      beat_d = '0;
    end else if (beat_step) begin
      beat_d = beat_q + 2'd1;
    end else begin
      beat_d = beat_q;
    end
  end

  // Offset and beat registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
      beat_q   <= '0;
    end else begin
      offset_q <= offset_d;
      beat_q   <= beat_d;
    end
  end

  assign offset    = offset_q;
  assign last_beat = (beat_q == LAST_BEAT);

endmodule

// File: rtl/mem_bus_responder.sv
// Paged memory bus responder: answers 4-beat read and write bursts on a
// multiplexed address/data bus for one 4K-word page of an external array.
// All outputs are decoded from the state and offset flops, so reset clears
// them immediately; write data flows straight from the bus to the array in
// the beat cycle, and read data flows straight from the array to the bus.
module mem_bus_responder import mcDefs::*; #(
  parameter logic [PAGE_W-1:0] PAGE  = 4'h0,
  parameter int                BURST = BURST_LEN
) (
  input  logic                clk,
  input  logic                resetH,
  input  logic [DATA_W-1:0]   AddrData_in,
  input  logic                AddrValid,
  input  logic                rw,
  output logic [DATA_W-1:0]   AddrData_out,
  output logic                AddrData_oe,
  output logic [OFFSET_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e              state_d, state_q;
  logic                accept_s;
  logic                rd_issue_s;
  logic                wr_beat_s;
  logic                bus_beat_s;
  logic                last_beat_s;
  logic [OFFSET_W-1:0] offset_s;

  // An address phase is taken only while idle and only for our own page.
  assign accept_s = (state_q == ST_IDLE) && AddrValid &&
                    (AddrData_in[DATA_W-1:OFFSET_W] == PAGE);

  // Reads issue in RD_WAIT and in every RD_DATA beat except the last, since
  // the array answers one cycle later; writes issue on every WR_DATA beat.
  assign rd_issue_s = (state_q == ST_RD_WAIT) ||
                      ((state_q == ST_RD_DATA) && !last_beat_s);
  assign wr_beat_s  = (state_q == ST_WR_DATA);
  assign bus_beat_s = (state_q == ST_RD_DATA) || (state_q == ST_WR_DATA);

  burst_addr_gen #(
    .BURST(BURST)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (resetH),
    .load       (accept_s),
    .load_offset(AddrData_in[OFFSET_W-1:0]),
    .addr_step  (rd_issue_s || wr_beat_s),
    .beat_step  (bus_beat_s),
    .offset     (offset_s),
    .last_beat  (last_beat_s)
  );

  // Burst sequencing; address phases seen mid-burst are simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = rw ? ST_RD_WAIT : ST_WR_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (last_beat_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_WR_DATA: begin
        if (last_beat_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WR_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign mem_re       = rd_issue_s;
  assign mem_we       = wr_beat_s;
  assign mem_addr     = offset_s;
  assign mem_wdata    = wr_beat_s ? AddrData_in : 16'h0000;
  assign AddrData_oe  = (state_q == ST_RD_DATA);
  assign AddrData_out = AddrData_oe ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder (PAGE=1) with a synchronous
// 4K-word array model whose unwritten words read back as {page, offset}.
module tb_mem_bus_responder;
  import mcDefs::*;

  logic        clk = 1'b0;
  logic        resetH;
  logic [15:0] AddrData_in;
  logic        AddrValid;
  logic        rw;
  logic [15:0] AddrData_out;
  logic        AddrData_oe;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_q [$];
  logic [15:0] mem [4096];
  bit          written [4096];

  always #5 clk = ~clk;

  mem_bus_responder #(
    .PAGE (4'h1),
    .BURST(4)
  ) dut (
    .clk         (clk),
    .resetH      (resetH),
    .AddrData_in (AddrData_in),
    .AddrValid   (AddrValid),
    .rw          (rw),
    .AddrData_out(AddrData_out),
    .AddrData_oe (AddrData_oe),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata)
  );

  // Array model: one write per cycle, registered read data.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    if (mem_re) begin
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : {4'h1, mem_addr};
    end
  end

  // Present one address phase; returns 1 time unit after the accepting edge.
  task automatic drive_addr(input logic [15:0] a, input logic r);
    AddrValid   = 1'b1;
    AddrData_in = a;
    rw          = r;
    @(posedge clk);
    #1;
    AddrValid   = 1'b0;
    AddrData_in = 16'h0000;
  endtask

  // Follow a read burst for 6 cycles, popping expected words as oe rises.
  task automatic read_beats(input logic [11:0] base, input bit inject);
    logic        exp_re;
    logic        exp_oe;
    logic [11:0] ea;
    logic [15:0] e;
    for (int k = 1; k <= 6; k++) begin
      if (inject && k <= 3) begin
        AddrValid   = 1'b1;
        AddrData_in = 16'h1500;
        rw          = 1'b0;
      end else begin
        AddrValid   = 1'b0;
        AddrData_in = 16'h0000;
      end
      @(negedge clk);
      exp_re = (k <= 4);
      exp_oe = (k >= 2 && k <= 5);
      ea     = base + 12'(k - 1);
      n_vec++;
      if (mem_re !== exp_re) begin
        n_err++; $display("FAIL rd_mem_re cycle %0d: got %b expected %b", k, mem_re, exp_re);
      end
      if (exp_re) begin
        n_vec++;
        if (mem_addr !== ea) begin
          n_err++; $display("FAIL rd_mem_addr cycle %0d: got %h expected %h", k, mem_addr, ea);
        end
      end
      n_vec++;
      if (AddrData_oe !== exp_oe) begin
        n_err++; $display("FAIL rd_oe cycle %0d: got %b expected %b", k, AddrData_oe, exp_oe);
      end
      if (AddrData_oe === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rd_extra_beat cycle %0d: got %h expected none", k, AddrData_out);
        end else begin
          e = exp_q.pop_front();
          if (AddrData_out !== e) begin
            n_err++; $display("FAIL rd_data cycle %0d: got %h expected %h", k, AddrData_out, e);
          end
        end
      end
      n_vec++;
      if (mem_we !== 1'b0) begin
        n_err++; $display("FAIL rd_no_we cycle %0d: got %b expected 0", k, mem_we);
      end
      @(posedge clk);
      #1;
    end
    rw = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rd_missing_beats: got %0d left expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  // Drive four write beats and check the array strobes in each beat cycle.
  task automatic write_beats(input logic [11:0] base, input logic [63:0] d);
    logic [15:0] beat;
    logic [11:0] ea;
    for (int n = 0; n < 4; n++) begin
      beat        = d[16*(3-n) +: 16];
      ea          = base + 12'(n);
      AddrData_in = beat;
      @(negedge clk);
      n_vec++;
      if (mem_we !== 1'b1 || mem_re !== 1'b0 || AddrData_oe !== 1'b0) begin
        n_err++; $display("FAIL wr_strobes beat %0d: got we=%b re=%b oe=%b expected we=1 re=0 oe=0",
                          n, mem_we, mem_re, AddrData_oe);
      end
      n_vec++;
      if (mem_wdata !== beat || mem_addr !== ea) begin
        n_err++; $display("FAIL wr_beat %0d: got addr=%h data=%h expected addr=%h data=%h",
                          n, mem_addr, mem_wdata, ea, beat);
      end
      @(posedge clk);
      #1;
    end
    AddrData_in = 16'h0000;
    #1;
    n_vec++;
    if (mem_we !== 1'b0) begin
      n_err++; $display("FAIL wr_end_we: got %b expected 0", mem_we);
    end
  endtask

  task automatic test_reset();
    resetH = 1'b1; AddrValid = 1'b0; AddrData_in = 16'h0000; rw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || AddrData_oe !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: got we=%b re=%b oe=%b expected 0 0 0", mem_we, mem_re, AddrData_oe);
    end
    n_vec++;
    if (mem_addr !== 12'h000 || mem_wdata !== 16'h0000 || AddrData_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_buses: got addr=%h wdata=%h out=%h expected 0 0 0", mem_addr, mem_wdata, AddrData_out);
    end
    @(posedge clk);
    #1;
    resetH = 1'b0;
  endtask

  task automatic test_read();
    drive_addr(16'h1010, 1'b1);
    exp_q.push_back(16'h1010); exp_q.push_back(16'h1011);
    exp_q.push_back(16'h1012); exp_q.push_back(16'h1013);
    read_beats(12'h010, 1'b0);
  endtask

  task automatic test_page_mismatch();
    drive_addr(16'h2000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (mem_re !== 1'b0 || mem_we !== 1'b0 || AddrData_oe !== 1'b0) begin
        n_err++; $display("FAIL mismatch_rd cycle %0d: got re=%b we=%b oe=%b expected 0 0 0", k, mem_re, mem_we, AddrData_oe);
      end
    end
    @(posedge clk); #1;
    drive_addr(16'h2000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      AddrData_in = 16'h5A5A;
      @(negedge clk);
      n_vec++;
      if (mem_we !== 1'b0) begin
        n_err++; $display("FAIL mismatch_wr cycle %0d: got we=%b expected 0", k, mem_we);
      end
      @(posedge clk); #1;
    end
    AddrData_in = 16'h0000;
  endtask

  task automatic test_wrap_write();
    drive_addr(16'h1FFE, 1'b0);
    write_beats(12'hFFE, {16'hAAA1, 16'hBBB2, 16'hCCC3, 16'hDDD4});
    n_vec++;
    if (mem[12'hFFE] !== 16'hAAA1 || mem[12'hFFF] !== 16'hBBB2 ||
        mem[12'h000] !== 16'hCCC3 || mem[12'h001] !== 16'hDDD4) begin
      n_err++; $display("FAIL wrap_array: got %h %h %h %h expected aaa1 bbb2 ccc3 ddd4",
                        mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]);
    end
  endtask

  task automatic test_reset_mid_write();
    drive_addr(16'h1100, 1'b0);
    AddrData_in = 16'hA0A0;
    @(posedge clk); #1;
    AddrData_in = 16'hB0B0;
    @(posedge clk); #1;
    AddrData_in = 16'hC0C0;
    resetH = 1'b1;
    #1;
    n_vec++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || AddrData_oe !== 1'b0 ||
        mem_addr !== 12'h000 || mem_wdata !== 16'h0000 || AddrData_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_abort_outputs: got we=%b re=%b oe=%b addr=%h wdata=%h out=%h expected all 0",
                        mem_we, mem_re, AddrData_oe, mem_addr, mem_wdata, AddrData_out);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetH = 1'b0;
    AddrData_in = 16'h0000;
    n_vec++;
    if (mem[12'h100] !== 16'hA0A0 || mem[12'h101] !== 16'hB0B0 ||
        written[12'h102] !== 1'b0 || written[12'h103] !== 1'b0) begin
      n_err++; $display("FAIL reset_abort_array: got %h %h w102=%b w103=%b expected a0a0 b0b0 0 0",
                        mem[12'h100], mem[12'h101], written[12'h102], written[12'h103]);
    end
    drive_addr(16'h1100, 1'b1);
    exp_q.push_back(16'hA0A0); exp_q.push_back(16'hB0B0);
    exp_q.push_back(16'h1102); exp_q.push_back(16'h1103);
    read_beats(12'h100, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_addr(16'h1200, 1'b0);
    write_beats(12'h200, {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0});
    drive_addr(16'h1200, 1'b1);
    exp_q.push_back(16'h1234); exp_q.push_back(16'h5678);
    exp_q.push_back(16'h9ABC); exp_q.push_back(16'hDEF0);
    read_beats(12'h200, 1'b0);
  endtask

  task automatic test_ignore_mid_burst();
    drive_addr(16'h1300, 1'b1);
    exp_q.push_back(16'h1300); exp_q.push_back(16'h1301);
    exp_q.push_back(16'h1302); exp_q.push_back(16'h1303);
    read_beats(12'h300, 1'b1);
    n_vec++;
    if (written[12'h500] !== 1'b0) begin
      n_err++; $display("FAIL ignore_no_write: got written=%b expected 0", written[12'h500]);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_page_mismatch();
    test_read();
    test_wrap_write();
    test_reset_mid_write();
    test_back_to_back();
    test_ignore_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter PAGE, 4'h0, page number this responder answers to; compared with address bits [15:12].
REQ-002 Parameter BURST, 4, beats per transfer; fixed at 4 in mcDefs.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 resetH  input  1  asynchronous, active-high reset.
REQ-005 AddrData_in  input  16  multiplexed address/data bus as driven by the master.
REQ-006 AddrValid  input  1  master qualifies an address phase on AddrData_in.
REQ-007 rw  input  1  sampled with AddrValid: 1 = read, 0 = write.
REQ-008 AddrData_out  output  16  read data driven toward the bus.
REQ-009 AddrData_oe  output  1  bus drive enable; the top level builds the tri-state from it.
REQ-010 mem_addr  output  12  word address into the page array.
REQ-011 mem_wdata  output  16  write data to the array.
REQ-012 mem_we  output  1  array write strobe, one word per cycle.
REQ-013 mem_re  output  1  array read strobe; mem_rdata is valid the following cycle.
REQ-014 mem_rdata  input  16  array read data.

Function
REQ-015 States SHALL be IDLE, RD_WAIT, RD_DATA and WR_DATA; a 2-bit beat counter and a 12-bit offset register SHALL be kept.
REQ-016 In IDLE, AddrValid=1 with AddrData_in[15:12]==PAGE SHALL latch offset=AddrData_in[11:0], clear the beat counter and go to RD_WAIT (rw=1) or WR_DATA (rw=0); a page mismatch SHALL be ignored.
REQ-017 Read, address at edge T: mem_re=1 on cycles T+1..T+4 with mem_addr = offset+0..3; AddrData_oe=1 and AddrData_out = the returned word on cycles T+2..T+5.
REQ-018 RD_WAIT SHALL last exactly one cycle; RD_DATA SHALL last 4 cycles, then IDLE with AddrData_oe=0 on the next cycle.
REQ-019 Write, address at edge T: data beats on AddrData_in at T+1..T+4; each beat SHALL produce mem_we=1, mem_wdata=beat and mem_addr=offset+n in the same cycle; IDLE after beat 3.
REQ-020 The offset SHALL increment modulo 4096, so 12'hFFF wraps to 12'h000 and never leaves the page.
REQ-021 AddrValid asserted during a burst SHALL be ignored; no overlap or pipelining of bursts.
REQ-022 AddrValid in the cycle after the last beat SHALL be accepted (back-to-back bursts allowed).
REQ-023 mem_we and mem_re SHALL never be asserted together; AddrData_oe SHALL never be 1 in IDLE or WR_DATA.

Reset
REQ-024 resetH=1 SHALL asynchronously force IDLE, beat=0, offset=0, AddrData_oe=0, AddrData_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-burst SHALL abort the burst; no further array write is issued after resetH rises.
REQ-026 The first address phase SHALL be accepted on the first rising edge after resetH falls.

Structure
REQ-027 The state enum, the page, offset and data widths, BURST, and the read latency (1) SHALL be in mcDefs.
REQ-028 One sub-module, burst_addr_gen, SHALL hold the offset register, the beat counter, the wrap logic and the last-beat flag.

Verification
REQ-029 Read at 16'h1010 with PAGE=1 (array preloaded word=addr) -> oe high for 4 cycles at T+2..T+5 with data 0x1010,0x1011,0x1012,0x1013.
REQ-030 Write at 16'h1FFE with beats A,B,C,D -> array 0xFFE=A, 0xFFF=B, 0x000=C, 0x001=D.
REQ-031 Address 16'h2000 with PAGE=1 -> no mem_re, mem_we or oe, state stays IDLE.
REQ-032 resetH pulsed after beat 1 of a write at 16'h1100 -> only 0x100 and 0x101 written; outputs zero right away; a read issued next returns the correct data.
REQ-033 Write burst then read burst with AddrValid in the cycle after the last write beat -> both accepted, read returns the written words.
REQ-034 AddrValid with page match pulsed during a read burst -> ignored; original 4 beats complete unchanged.
